// File: rtl/clz_64.sv
// ============================================================================
// clz_64 : registered count-leading-zeros of a 64-bit word (result 0..64)
// Revision: 1.0
// ============================================================================
`default_nettype none

module clz_64 #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] out,
    output logic                 all_zero
);

    if (WIDTH != 64 || CNT_WIDTH != 7) begin : g_bad_param
        $error("clz_64 supports only WIDTH=64 and CNT_WIDTH=7");
    end

    // Level 0: sixteen nibble units, nibble 0 holds bits [63:60]
    logic [1:0] w_c0 [16];
    logic       w_z0 [16];
    logic [2:0] w_c1 [8];
    logic       w_z1 [8];
    logic [3:0] w_c2 [4];
    logic       w_z2 [4];
    logic [4:0] w_c3 [2];
    logic       w_z3 [2];
    logic [5:0] w_c4;
    logic       w_z4;
    logic [6:0] w_count;

    for (genvar n = 0; n < 16; n++) begin : g_nib
        logic [3:0] w_nib;
        assign w_nib  = in[63-4*n -: 4];
        assign w_z0[n] = ~|w_nib;
        assign w_c0[n] = w_nib[3] ? 2'd0 :
                         w_nib[2] ? 2'd1 :
                         w_nib[1] ? 2'd2 : 2'd3;
    end

    // Each merge takes the left count unless the left half is empty
    for (genvar i = 0; i < 8; i++) begin : g_l1
        assign w_z1[i] = w_z0[2*i] & w_z0[2*i+1];
        assign w_c1[i] = w_z0[2*i] ? {1'b1, w_c0[2*i+1]} : {1'b0, w_c0[2*i]};
    end

    for (genvar i = 0; i < 4; i++) begin : g_l2
        assign w_z2[i] = w_z1[2*i] & w_z1[2*i+1];
        assign w_c2[i] = w_z1[2*i] ? {1'b1, w_c1[2*i+1]} : {1'b0, w_c1[2*i]};
    end

    for (genvar i = 0; i < 2; i++) begin : g_l3
        assign w_z3[i] = w_z2[2*i] & w_z2[2*i+1];
        assign w_c3[i] = w_z2[2*i] ? {1'b1, w_c2[2*i+1]} : {1'b0, w_c2[2*i]};
    end

    assign w_z4 = w_z3[0] & w_z3[1];
    assign w_c4 = w_z3[0] ? {1'b1, w_c3[1]} : {1'b0, w_c3[0]};

    // The tree yields 63 for an empty word; the all-zero case is forced to 64
    assign w_count = w_z4 ? 7'd64 : {1'b0, w_c4};

    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_out;
    logic                 r_all_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_all_zero <= 1'b0;
        end else if (in_valid) begin
            r_valid    <= 1'b1;
            r_out      <= w_count;
            r_all_zero <= w_z4;
        end else begin
            r_valid    <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign all_zero  = r_all_zero;

endmodule

`default_nettype wire

// File: tb/tb_clz_64.sv
// ============================================================================
// tb_clz_64 : scoreboard bench for clz_64
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clz_64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in;
    logic        out_valid;
    logic [6:0]  out;
    logic        all_zero;

    clz_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in),
        .out_valid (out_valid),
        .out       (out),
        .all_zero  (all_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_bad;
    logic [7:0] sb_q [$];   // {all_zero, out}
    logic [8:0] got;
    logic [8:0] exp;

    // Independent reference: position of the highest set bit by linear scan
    function automatic logic [7:0] ref_clz(input logic [63:0] d);
        logic [6:0] c;
        c = 7'd64;
        for (int k = 0; k < 64; k++)
            if (d[k]) c = 7'(63 - k);
        return {(c == 7'd64), c};
    endfunction

    // Drive one word at the falling edge, queue its expectation, step past the rising edge
    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] e);
        @(negedge clk);
        in_valid = v;
        in       = d;
        if (v) sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; in = 64'h1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            got = {out_valid, all_zero, out};
            n_cmp++;
            if (got !== 9'h0) begin
                n_bad++;
                $display("FAIL reset_hold: got %b expected %b", got, 9'h0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        drive(1'b1, 64'h1, {1'b0, 7'd63});
        got = {out_valid, all_zero, out};
        exp = {1'b1, sb_q.pop_front()};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_first: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_walking;
        for (int k = 0; k < 64; k++) begin
            drive(1'b1, 64'h1 << k, {1'b0, 7'(63 - k)});
            got = {out_valid, all_zero, out};
            exp = {1'b1, sb_q.pop_front()};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL walking_one k=%0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_zero;
        logic [63:0] pats [2];
        logic [7:0]  exps [2];
        pats[0] = 64'h0;                   exps[0] = {1'b1, 7'd64};
        pats[1] = 64'h8000_0000_0000_0000; exps[1] = {1'b0, 7'd0};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, pats[i], exps[i]);
            got = {out_valid, all_zero, out};
            exp = {1'b1, sb_q.pop_front()};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL zero_input %0d: got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_adder;
        logic [63:0] pats [3];
        logic [7:0]  exps [3];
        pats[0] = {11'b0, 53'h1F_FFFF_FFFF_FFFF}; exps[0] = {1'b0, 7'd11};
        pats[1] = {11'b0, 53'h0_0000_0000_0001};  exps[1] = {1'b0, 7'd63};
        pats[2] = {11'b0, 53'h0};                 exps[2] = {1'b1, 7'd64};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pats[i], exps[i]);
            got = {out_valid, all_zero, out};
            exp = {1'b1, sb_q.pop_front()};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL adder_case %0d: got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_hold;
        drive(1'b1, 64'h0400_0000_0000_0000, {1'b0, 7'd5});
        got = {out_valid, all_zero, out};
        exp = {1'b1, sb_q.pop_front()};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL hold_load: got %b expected %b", got, exp);
        end
        drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0);
        got = {out_valid, all_zero, out};
        n_cmp++;
        if (got !== {1'b0, 1'b0, 7'd5}) begin
            n_bad++;
            $display("FAIL hold_idle: got %b expected %b", got, {1'b0, 1'b0, 7'd5});
        end
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, {1'b0, 7'd0});
        got = {out_valid, all_zero, out};
        exp = {1'b1, sb_q.pop_front()};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL hold_resume: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_random;
        logic [63:0] d;
        int          lz;
        for (int i = 0; i < 10000; i++) begin
            d  = {$urandom, $urandom};
            lz = $urandom_range(0, 64);
            d  = d & (64'hFFFF_FFFF_FFFF_FFFF >> lz);
            drive(1'b1, d, ref_clz(d));
            got = {out_valid, all_zero, out};
            exp = {1'b1, sb_q.pop_front()};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random i=%0d in=%h: got %b expected %b", i, d, got, exp);
            end
            if (i == 5000) begin
                // Mid-cycle pulse: outputs must clear with no clock edge
                #1 rst_n = 1'b0;
                #1;
                got = {out_valid, all_zero, out};
                n_cmp++;
                if (got !== 9'h0) begin
                    n_bad++;
                    $display("FAIL async_reset: got %b expected %b", got, 9'h0);
                end
                @(negedge clk);
                in_valid = 1'b0;
                rst_n    = 1'b1;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in = 64'h1;
        test_reset();
        test_walking();
        test_zero();
        test_adder();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
